// File: rtl/mlsd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlsd_pkg
// Description : Shared types and helpers for the sequence-detector datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package mlsd_pkg;

   // Two-bit signed symbol hypothesized by a path.
   typedef logic signed [1:0] sym_t;

   // Control states of the path-metric stage.
   typedef enum logic [0:0] {
      FILL = 1'b0,
      RUN  = 1'b1
   } pm_state_t;

   // Largest value of a 2*bw-bit unsigned energy word (all ones).
   function automatic logic [63:0] e_max(input int bw);
      logic [63:0] one;
      one = 64'd1;
      return (one << (2 * bw)) - one;
   endfunction

endpackage
`default_nettype wire

// File: rtl/path_metric_slice.sv
`default_nettype none
// ============================================================================
// Module      : path_metric_slice
// Description : One path: normalize by the fed-back minimum (clamped at 0),
//               add the branch energy, saturate, and shift the symbol history.
// Revision    : 1.0 - initial release
// ============================================================================
module path_metric_slice
   import mlsd_pkg::*;
#(
   parameter int H_DEPTH   = 4,
   parameter int B_WIDTH   = 8,
   parameter bit INIT_ZERO = 1'b0
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   restart,
   input  logic                   accept,
   input  logic [2*B_WIDTH-1:0]   branch_energy,
   input  sym_t                   branch_symbol,
   input  logic [2*B_WIDTH-1:0]   norm_energy,
   output logic [2*B_WIDTH-1:0]   energy,
   output sym_t [H_DEPTH-1:0]     history
);

   localparam int                EW       = 2 * B_WIDTH;
   localparam logic [63:0]       E_MAX_64 = e_max(B_WIDTH);
   localparam logic [EW-1:0]     E_MAX    = E_MAX_64[EW-1:0];
   // Path 0 starts as the survivor; every other path starts "infinitely" bad.
   localparam logic [EW-1:0]     E_START  = INIT_ZERO ? {EW{1'b0}} : E_MAX;

   logic [EW-1:0] diff;
   logic [EW:0]   sum;
   logic [EW-1:0] energy_nx;

   // Normalize with a floor at zero (tolerates a stale norm), add, saturate.
   always_comb begin
      diff      = (energy >= norm_energy) ? (energy - norm_energy) : {EW{1'b0}};
      sum       = {1'b0, diff} + {1'b0, branch_energy};
      energy_nx = sum[EW] ? E_MAX : sum[EW-1:0];
   end

   // Energy register: start value on reset/restart, update on accept.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         energy <= E_START;
      end else if (restart) begin
         energy <= E_START;
      end else if (accept) begin
         energy <= energy_nx;
      end
   end

   generate
      if (H_DEPTH == 1) begin : g_hist_single
         // Single-entry history simply captures the newest symbol.
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               history <= '0;
            end else if (restart) begin
               history <= '0;
            end else if (accept) begin
               history[0] <= branch_symbol;
            end
         end
      end else begin : g_hist_shift
         // Newest symbol enters at index 0; the oldest falls off the top.
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               history <= '0;
            end else if (restart) begin
               history <= '0;
            end else if (accept) begin
               history <= {history[H_DEPTH-2:0], branch_symbol};
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/path_metric_update.sv
`default_nettype none
// ============================================================================
// Module      : path_metric_update
// Description : Registered path-metric stage feeding select_unit. Holds the
//               fill FSM, the history fill counter and out_valid; the per-path
//               arithmetic lives in path_metric_slice.
// Revision    : 1.0 - initial release
// ============================================================================
module path_metric_update
   import mlsd_pkg::*;
#(
   parameter int N_B     = 8,
   parameter int H_DEPTH = 4,
   parameter int B_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rstb,
   input  logic                              restart,
   input  logic                              in_valid,
   input  logic [N_B-1:0][2*B_WIDTH-1:0]     branch_energies,
   input  sym_t [N_B-1:0]                    branch_symbols,
   input  logic [2*B_WIDTH-1:0]              norm_energy,
   output logic [N_B-1:0][2*B_WIDTH-1:0]     path_energies,
   output sym_t [N_B-1:0][H_DEPTH-1:0]       path_histories,
   output logic                              out_valid,
   output logic                              hist_full
);

   localparam int             CW       = $clog2(H_DEPTH + 1);
   localparam logic [CW-1:0]  CNT_FULL = CW'(H_DEPTH);

   pm_state_t       state, state_nx;
   logic [CW-1:0]   fill_cnt, fill_cnt_nx;
   logic            accept;

   // restart dominates a simultaneous input sample.
   assign accept = in_valid & ~restart;

   // Next-state: count accepted updates while filling, stop once full.
   always_comb begin
      state_nx    = state;
      fill_cnt_nx = fill_cnt;
      if (restart) begin
         state_nx    = FILL;
         fill_cnt_nx = '0;
      end else if (in_valid && (state == FILL)) begin
         fill_cnt_nx = fill_cnt + CW'(1);
         if (fill_cnt_nx == CNT_FULL) begin
            state_nx = RUN;
         end
      end
   end

   // Control registers.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state     <= FILL;
         fill_cnt  <= '0;
         out_valid <= 1'b0;
         hist_full <= 1'b0;
      end else begin
         state     <= state_nx;
         fill_cnt  <= fill_cnt_nx;
         out_valid <= accept;
         hist_full <= (fill_cnt_nx == CNT_FULL);
      end
   end

   generate
      for (genvar g = 0; g < N_B; g++) begin : g_slice
         path_metric_slice #(
            .H_DEPTH   (H_DEPTH),
            .B_WIDTH   (B_WIDTH),
            .INIT_ZERO (g == 0)
         ) u_slice (
            .clk           (clk),
            .rstb          (rstb),
            .restart       (restart),
            .accept        (accept),
            .branch_energy (branch_energies[g]),
            .branch_symbol (branch_symbols[g]),
            .norm_energy   (norm_energy),
            .energy        (path_energies[g]),
            .history       (path_histories[g])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_path_metric_update.sv
`default_nettype none
// ============================================================================
// Module      : tb_path_metric_update
// Description : Self-checking bench: directed vector table, hand sequences
//               for history/restart/async reset, and a randomized run against
//               a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_path_metric_update;
   import mlsd_pkg::*;

   localparam int N_B = 4;
   localparam int HD  = 4;
   localparam int BW  = 8;
   localparam int EMX = 65535;

   logic                   clk = 1'b0;
   logic                   rstb;
   logic                   restart;
   logic                   in_valid;
   logic [N_B-1:0][15:0]   branch_energies;
   sym_t [N_B-1:0]         branch_symbols;
   logic [15:0]            norm_energy;
   logic [N_B-1:0][15:0]   path_energies;
   sym_t [N_B-1:0][HD-1:0] path_histories;
   logic                   out_valid;
   logic                   hist_full;

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int m_e[N_B];
   int m_h[N_B][HD];
   int m_cnt;
   int m_ov;

   path_metric_update #(.N_B(N_B), .H_DEPTH(HD), .B_WIDTH(BW)) dut (
      .clk             (clk),
      .rstb            (rstb),
      .restart         (restart),
      .in_valid        (in_valid),
      .branch_energies (branch_energies),
      .branch_symbols  (branch_symbols),
      .norm_energy     (norm_energy),
      .path_energies   (path_energies),
      .path_histories  (path_histories),
      .out_valid       (out_valid),
      .hist_full       (hist_full)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int hist_at(input int p, input int k);
      return int'($signed(path_histories[p][k]));
   endfunction

   // Drive inputs at the falling edge, let the rising edge happen, settle.
   task automatic cycle(input bit v, input bit r, input int norm,
                        input int br[N_B], input int sy[N_B]);
      @(negedge clk);
      in_valid    = v;
      restart     = r;
      norm_energy = 16'(norm);
      for (int i = 0; i < N_B; i++) begin
         branch_energies[i] = 16'(br[i]);
         branch_symbols[i]  = sym_t'(sy[i]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      int z[N_B] = '{default: 0};
      cycle(1'b0, 1'b0, 0, z, z);
   endtask

   task automatic check_start(input string tag);
      chk({tag, "_e0"}, path_energies[0], 0);
      for (int i = 1; i < N_B; i++) chk({tag, "_e"}, path_energies[i], EMX);
      for (int i = 0; i < N_B; i++)
         for (int k = 0; k < HD; k++) chk({tag, "_hist"}, hist_at(i, k), 0);
      chk({tag, "_ov"}, out_valid, 0);
      chk({tag, "_hf"}, hist_full, 0);
   endtask

   // Reference model: restart/accept/idle from the block's behavioural rules.
   task automatic model_start();
      for (int i = 0; i < N_B; i++) begin
         m_e[i] = (i == 0) ? 0 : EMX;
         for (int k = 0; k < HD; k++) m_h[i][k] = 0;
      end
      m_cnt = 0;
      m_ov  = 0;
   endtask

   task automatic model_step(input bit v, input bit r, input int norm,
                             input int br[N_B], input int sy[N_B]);
      if (r) begin
         model_start();
      end else if (v) begin
         for (int i = 0; i < N_B; i++) begin
            int d, s;
            d = (m_e[i] >= norm) ? m_e[i] - norm : 0;
            s = d + br[i];
            m_e[i] = (s > EMX) ? EMX : s;
            for (int k = HD - 1; k > 0; k--) m_h[i][k] = m_h[i][k-1];
            m_h[i][0] = (sy[i] >= 2) ? sy[i] - 4 : sy[i];
         end
         if (m_cnt < HD) m_cnt++;
         m_ov = 1;
      end else begin
         m_ov = 0;
      end
   endtask

   task automatic check_model(input int n);
      for (int i = 0; i < N_B; i++) begin
         chk($sformatf("rnd%0d_e%0d", n, i), path_energies[i], m_e[i]);
         for (int k = 0; k < HD; k++)
            chk($sformatf("rnd%0d_h%0d_%0d", n, i, k), hist_at(i, k), m_h[i][k]);
      end
      chk($sformatf("rnd%0d_ov", n), out_valid, m_ov);
      chk($sformatf("rnd%0d_hf", n), hist_full, (m_cnt == HD) ? 1 : 0);
   endtask

   typedef struct {
      bit valid;
      bit rst;
      int norm;
      int br[N_B];
      int exp_e[N_B];
      bit exp_ov;
      bit exp_hf;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int zs[N_B];
      int br[N_B];
      int sy[N_B];
      zs = '{default: 0};

      // Directed vectors, applied in order starting from the reset state.
      tbl[0]  = '{1, 0, 65535, '{100, 200, 300, 400}, '{100, 200, 300, 400}, 1, 0};
      tbl[1]  = '{1, 0, 100,   '{5, 6, 7, 8},         '{5, 106, 207, 308},   1, 0};
      tbl[2]  = '{0, 0, 999,   '{9, 9, 9, 9},         '{5, 106, 207, 308},   0, 0};
      tbl[3]  = '{1, 0, 5,     '{0, 64899, 0, 0},     '{0, 65000, 202, 303}, 1, 0};
      tbl[4]  = '{1, 0, 152,   '{0, 152, 0, 0},       '{0, 65000, 50, 151},  1, 1};
      tbl[5]  = '{1, 0, 0,     '{0, 1000, 0, 0},      '{0, 65535, 50, 151},  1, 1};
      tbl[6]  = '{1, 0, 80,    '{0, 0, 3, 0},         '{0, 65455, 3, 71},    1, 1};
      tbl[7]  = '{1, 0, 0,     '{65535, 65535, 65535, 65535},
                                '{65535, 65535, 65535, 65535}, 1, 1};
      tbl[8]  = '{1, 0, 0,     '{0, 1, 0, 0},         '{65535, 65535, 65535, 65535}, 1, 1};
      tbl[9]  = '{1, 0, 1,     '{0, 0, 0, 1},         '{65534, 65534, 65534, 65535}, 1, 1};
      tbl[10] = '{1, 1, 0,     '{7, 7, 7, 7},         '{0, 65535, 65535, 65535}, 0, 0};

      // ---- Reset, then hold through release with no input ----
      rstb = 1'b0; restart = 1'b0; in_valid = 1'b0; norm_energy = '0;
      branch_energies = '0; branch_symbols = '0;
      repeat (3) @(posedge clk);
      #1;
      check_start("reset");
      @(negedge clk);
      rstb = 1'b1;
      repeat (3) idle();
      check_start("post_release");

      // ---- Table-driven directed vectors ----
      for (int t = 0; t < 11; t++) begin
         cycle(tbl[t].valid, tbl[t].rst, tbl[t].norm, tbl[t].br, zs);
         for (int i = 0; i < N_B; i++)
            chk($sformatf("vec%0d_e%0d", t, i), path_energies[i], tbl[t].exp_e[i]);
         chk($sformatf("vec%0d_ov", t), out_valid, tbl[t].exp_ov);
         chk($sformatf("vec%0d_hf", t), hist_full, tbl[t].exp_hf);
      end

      // ---- History fill on path 0 with idle gaps ----
      begin
         int seq[5] = '{1, -1, 0, 1, -1};
         for (int n = 0; n < 5; n++) begin
            sy = zs;
            sy[0] = seq[n] & 3;
            cycle(1'b1, 1'b0, 0, zs, sy);
            chk($sformatf("fill%0d_ov", n), out_valid, 1);
            chk($sformatf("fill%0d_hf", n), hist_full, (n >= 3) ? 1 : 0);
            if (n == 3) begin
               chk("fill4_h0", hist_at(0, 0), 1);
               chk("fill4_h1", hist_at(0, 1), 0);
               chk("fill4_h2", hist_at(0, 2), -1);
               chk("fill4_h3", hist_at(0, 3), 1);
            end
            idle();
            chk($sformatf("gap%0d_ov", n), out_valid, 0);
         end
         chk("fill5_h0", hist_at(0, 0), -1);
         chk("fill5_h1", hist_at(0, 1), 1);
         chk("fill5_h2", hist_at(0, 2), 0);
         chk("fill5_h3", hist_at(0, 3), -1);
         chk("fill5_e0", path_energies[0], 0);
      end

      // ---- restart together with in_valid after 3 updates ----
      cycle(1'b0, 1'b1, 0, zs, zs);
      br = '{11, 22, 33, 44};
      sy = '{1, 3, 1, 3};
      repeat (3) cycle(1'b1, 1'b0, 0, br, sy);
      chk("pre_restart_e0", path_energies[0], 33);
      cycle(1'b1, 1'b1, 0, br, sy);
      check_start("restart_valid");
      for (int n = 0; n < 4; n++) begin
         cycle(1'b1, 1'b0, 0, zs, zs);
         chk($sformatf("refill%0d_hf", n), hist_full, (n == 3) ? 1 : 0);
      end

      // ---- Async reset between edges while out_valid is high ----
      cycle(1'b1, 1'b0, 0, br, sy);
      chk("async_pre_ov", out_valid, 1);
      #2;
      rstb = 1'b0;
      #1;
      check_start("async");
      in_valid = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      idle();
      check_start("async_release");

      // ---- Randomized run against the reference model ----
      model_start();
      for (int n = 0; n < 400; n++) begin
         bit v, r;
         int norm, mn, sel;
         v = ($urandom_range(0, 9) < 7);
         r = ($urandom_range(0, 39) == 0);
         sel = $urandom_range(0, 9);
         mn = m_e[0];
         for (int i = 1; i < N_B; i++) if (m_e[i] < mn) mn = m_e[i];
         if (sel < 6)      norm = mn;
         else if (sel < 8) norm = $urandom_range(0, 65535);
         else              norm = 0;
         for (int i = 0; i < N_B; i++) begin
            br[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(60000, 65535)
                                                : $urandom_range(0, 3000);
            sy[i] = $urandom_range(0, 3);
         end
         cycle(v, r, norm, br, sy);
         model_step(v, r, norm, br, sy);
         check_model(n);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
